nv_nvdla_sdp_core_gpack: RTL and testbench

NV_NVDLA_SDP_CORE_GPACK -- requirements
Module: NV_NVDLA_SDP_CORE_gpack

---
 rtl/nv_nvdla_sdp_core_gpack.sv | 147 ++++++++++++++
 tb/tb_nv_nvdla_sdp_core_gpack.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_sdp_core_gpack.sv
// Packs IW-bit input beats into OW-bit output words (RATIO segments) with a per-segment mask.
// inp_last closes a word early; a closed word waits in assembly (HOLD) when the output register is stalled.
module nv_nvdla_sdp_core_gpack #(
   parameter int IW    = 128,
   parameter int OW    = 512,
   parameter int RATIO = OW / IW
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             inp_pvld,
   output logic             inp_prdy,
   input  logic [IW-1:0]    inp_data,
   input  logic             inp_last,
   output logic             out_pvld,
   input  logic             out_prdy,
   output logic [OW-1:0]    out_data,
   output logic [RATIO-1:0] out_mask,
   output logic             out_last
);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      PART = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] LAST_SEG = 4'(RATIO - 1);

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [OW-1:0]    asm_data, asm_data_nxt;
   logic [RATIO-1:0] asm_mask, asm_mask_nxt;
   logic             hold_last, hold_last_nxt;

   logic             hold;
   logic             inp_acc;
   logic             closing;
   logic             out_free;
   logic [OW-1:0]    cls_data;
   logic [RATIO-1:0] cls_mask;
   logic             out_load;
   logic [OW-1:0]    load_data;
   logic [RATIO-1:0] load_mask;
   logic             load_last;

   assign hold     = (state == HOLD);
   assign inp_prdy = !hold;
   assign inp_acc  = inp_pvld & inp_prdy;
   assign closing  = inp_acc & ((cnt == LAST_SEG) | inp_last);
   assign out_free = !out_pvld | out_prdy;

   // Assembly contents with the current beat merged into segment cnt.
   always_comb begin
      cls_data = asm_data;
      cls_mask = asm_mask;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (cnt == 4'(k)) begin
            cls_data[k*IW +: IW] = inp_data;
            cls_mask[k]          = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      asm_data_nxt  = asm_data;
      asm_mask_nxt  = asm_mask;
      hold_last_nxt = hold_last;
      out_load      = 1'b0;
      load_data     = asm_data;
      load_mask     = asm_mask;
      load_last     = hold_last;
      unique case (state)
         FILL, PART: begin
            if (inp_acc) begin
               if (closing) begin
                  cnt_nxt = '0;
                  if (out_free) begin
                     out_load     = 1'b1;
                     load_data    = cls_data;
                     load_mask    = cls_mask;
                     load_last    = inp_last;
                     asm_data_nxt = '0;
                     asm_mask_nxt = '0;
                     state_nxt    = FILL;
                  end else begin
                     asm_data_nxt  = cls_data;
                     asm_mask_nxt  = cls_mask;
                     hold_last_nxt = inp_last;
                     state_nxt     = HOLD;
                  end
               end else begin
                  cnt_nxt      = cnt + 4'd1;
                  asm_data_nxt = cls_data;
                  asm_mask_nxt = cls_mask;
                  state_nxt    = PART;
               end
            end
         end
         HOLD: begin
            // Output register is always occupied here; it frees on out_prdy.
            if (out_prdy) begin
               out_load      = 1'b1;
               asm_data_nxt  = '0;
               asm_mask_nxt  = '0;
               hold_last_nxt = 1'b0;
               state_nxt     = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state     <= FILL;
         cnt       <= '0;
         asm_data  <= '0;
         asm_mask  <= '0;
         hold_last <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         asm_data  <= asm_data_nxt;
         asm_mask  <= asm_mask_nxt;
         hold_last <= hold_last_nxt;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         out_pvld <= 1'b0;
         out_data <= '0;
         out_mask <= '0;
         out_last <= 1'b0;
      end else if (out_load) begin
         out_pvld <= 1'b1;
         out_data <= load_data;
         out_mask <= load_mask;
         out_last <= load_last;
      end else if (out_prdy) begin
         out_pvld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nv_nvdla_sdp_core_gpack.sv
// Bench for nv_nvdla_sdp_core_gpack: directed scenarios on RATIO=4 and RATIO=1 instances,
// then a long randomized run against a queue-based word model.
module tb_nv_nvdla_sdp_core_gpack;

   localparam int IW = 16;

   logic clk = 1'b0;
   logic rstn;

   logic          p4_vld, p4_rdy, p4_last, o4_vld, o4_rdy, o4_last;
   logic [15:0]   p4_data;
   logic [63:0]   o4_data;
   logic [3:0]    o4_mask;

   logic          p1_vld, p1_rdy, p1_last, o1_vld, o1_rdy, o1_last;
   logic [15:0]   p1_data;
   logic [15:0]   o1_data;
   logic [0:0]    o1_mask;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   nv_nvdla_sdp_core_gpack #(.IW(IW), .OW(64)) dut4 (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .inp_pvld       (p4_vld),
      .inp_prdy       (p4_rdy),
      .inp_data       (p4_data),
      .inp_last       (p4_last),
      .out_pvld       (o4_vld),
      .out_prdy       (o4_rdy),
      .out_data       (o4_data),
      .out_mask       (o4_mask),
      .out_last       (o4_last)
   );

   nv_nvdla_sdp_core_gpack #(.IW(IW), .OW(16)) dut1 (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .inp_pvld       (p1_vld),
      .inp_prdy       (p1_rdy),
      .inp_data       (p1_data),
      .inp_last       (p1_last),
      .out_pvld       (o1_vld),
      .out_prdy       (o1_rdy),
      .out_data       (o1_data),
      .out_mask       (o1_mask),
      .out_last       (o1_last)
   );

   // Inputs change only at negedge; each call spans exactly one rising edge.
   task automatic drive4(input logic v, input logic [15:0] d, input logic l, input logic r);
      p4_vld = v; p4_data = d; p4_last = l; o4_rdy = r;
      @(negedge clk);
   endtask

   task automatic drive1(input logic v, input logic [15:0] d, input logic l, input logic r);
      p1_vld = v; p1_data = d; p1_last = l; o1_rdy = r;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      p4_vld = 0; p4_data = '0; p4_last = 0; o4_rdy = 0;
      p1_vld = 0; p1_data = '0; p1_last = 0; o1_rdy = 0;
      @(negedge clk); @(negedge clk);
      vectors++; if (o4_vld !== 1'b0) begin miscompares++; $display("FAIL reset_out_pvld: got %b expected 0", o4_vld); end
      vectors++; if (o4_data !== 64'h0) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0", o4_data); end
      vectors++; if (o4_mask !== 4'h0) begin miscompares++; $display("FAIL reset_out_mask: got %b expected 0000", o4_mask); end
      vectors++; if (o4_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b expected 0", o4_last); end
      vectors++; if (p4_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_inp_prdy: got %b expected 1", p4_rdy); end
      vectors++; if (o1_vld !== 1'b0 || p1_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_r1: got vld=%b rdy=%b expected vld=0 rdy=1", o1_vld, p1_rdy); end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_word;
      logic [15:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = 16'($urandom);
      for (int i = 0; i < 3; i++) drive4(1'b1, b[i], 1'b0, 1'b1);
      vectors++; if (o4_vld !== 1'b0) begin miscompares++; $display("FAIL full_early_vld: got %b expected 0", o4_vld); end
      drive4(1'b1, b[3], 1'b0, 1'b1);
      vectors++; if (o4_vld !== 1'b1) begin miscompares++; $display("FAIL full_vld: got %b expected 1", o4_vld); end
      vectors++; if (o4_data !== {b[3], b[2], b[1], b[0]}) begin miscompares++; $display("FAIL full_data: got %h expected %h", o4_data, {b[3], b[2], b[1], b[0]}); end
      vectors++; if (o4_mask !== 4'b1111 || o4_last !== 1'b0) begin miscompares++; $display("FAIL full_mask_last: got %b/%b expected 1111/0", o4_mask, o4_last); end
      drive4(1'b0, '0, 1'b0, 1'b1);
      vectors++; if (o4_vld !== 1'b0) begin miscompares++; $display("FAIL full_vld_clear: got %b expected 0", o4_vld); end
   endtask

   task automatic test_last;
      logic [15:0] b [6];
      for (int i = 0; i < 6; i++) b[i] = 16'($urandom);
      drive4(1'b1, b[0], 1'b0, 1'b1);
      drive4(1'b1, b[1], 1'b1, 1'b1);
      vectors++; if (o4_vld !== 1'b1 || o4_data !== {32'h0, b[1], b[0]}) begin miscompares++; $display("FAIL last_data: got vld=%b %h expected vld=1 %h", o4_vld, o4_data, {32'h0, b[1], b[0]}); end
      vectors++; if (o4_mask !== 4'b0011 || o4_last !== 1'b1) begin miscompares++; $display("FAIL last_mask_last: got %b/%b expected 0011/1", o4_mask, o4_last); end
      for (int i = 2; i < 6; i++) drive4(1'b1, b[i], 1'b0, 1'b1);
      vectors++; if (o4_data !== {b[5], b[4], b[3], b[2]} || o4_mask !== 4'b1111 || o4_last !== 1'b0) begin miscompares++; $display("FAIL last_next_seg0: got %h/%b/%b expected %h/1111/0", o4_data, o4_mask, o4_last, {b[5], b[4], b[3], b[2]}); end
      drive4(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_stall;
      logic [15:0] b [12];
      for (int i = 0; i < 12; i++) b[i] = 16'($urandom);
      for (int i = 0; i < 8; i++) drive4(1'b1, b[i], 1'b0, 1'b0);
      vectors++; if (p4_rdy !== 1'b0) begin miscompares++; $display("FAIL stall_prdy: got %b expected 0", p4_rdy); end
      vectors++; if (o4_vld !== 1'b1 || o4_data !== {b[3], b[2], b[1], b[0]}) begin miscompares++; $display("FAIL stall_word1: got vld=%b %h expected vld=1 %h", o4_vld, o4_data, {b[3], b[2], b[1], b[0]}); end
      // A beat offered while held must be refused.
      drive4(1'b1, b[8], 1'b0, 1'b0);
      vectors++; if (p4_rdy !== 1'b0 || o4_data !== {b[3], b[2], b[1], b[0]}) begin miscompares++; $display("FAIL stall_stable: got rdy=%b %h expected rdy=0 %h", p4_rdy, o4_data, {b[3], b[2], b[1], b[0]}); end
      drive4(1'b0, '0, 1'b0, 1'b1);
      vectors++; if (o4_vld !== 1'b1 || o4_data !== {b[7], b[6], b[5], b[4]} || o4_mask !== 4'b1111) begin miscompares++; $display("FAIL stall_word2: got vld=%b %h %b expected vld=1 %h 1111", o4_vld, o4_data, o4_mask, {b[7], b[6], b[5], b[4]}); end
      vectors++; if (p4_rdy !== 1'b1) begin miscompares++; $display("FAIL stall_reopen: got %b expected 1", p4_rdy); end
      drive4(1'b0, '0, 1'b0, 1'b1);
      vectors++; if (o4_vld !== 1'b0) begin miscompares++; $display("FAIL stall_drained: got %b expected 0", o4_vld); end
      for (int i = 9; i < 12; i++) drive4(1'b1, b[i], 1'b0, 1'b1);
      drive4(1'b1, b[0], 1'b0, 1'b1);
      vectors++; if (o4_data !== {b[0], b[11], b[10], b[9]}) begin miscompares++; $display("FAIL stall_no_residue: got %h expected %h", o4_data, {b[0], b[11], b[10], b[9]}); end
      drive4(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_ratio1;
      logic [15:0] d;
      logic        l;
      vectors++; if (o1_vld !== 1'b0) begin miscompares++; $display("FAIL r1_idle: got %b expected 0", o1_vld); end
      for (int i = 0; i < 8; i++) begin
         d = 16'($urandom);
         l = 1'($urandom_range(0, 1));
         drive1(1'b1, d, l, 1'b1);
         vectors++;
         if (o1_vld !== 1'b1 || o1_data !== d || o1_mask !== 1'b1 || o1_last !== l || p1_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL r1_beat%0d: got vld=%b %h m=%b l=%b rdy=%b expected vld=1 %h m=1 l=%b rdy=1", i, o1_vld, o1_data, o1_mask, o1_last, p1_rdy, d, l);
         end
      end
      drive1(1'b0, '0, 1'b0, 1'b1);
      vectors++; if (o1_vld !== 1'b0) begin miscompares++; $display("FAIL r1_drain: got %b expected 0", o1_vld); end
   endtask

   task automatic test_reset_mid;
      logic [15:0] b [4];
      for (int i = 0; i < 4; i++) drive4(1'b1, 16'($urandom), 1'b0, 1'b0);
      drive4(1'b1, 16'($urandom), 1'b0, 1'b0);
      drive4(1'b1, 16'($urandom), 1'b0, 1'b0);
      p4_vld = 1'b0;
      rstn = 1'b0;
      #1;
      vectors++; if (o4_vld !== 1'b0 || o4_data !== 64'h0 || o4_mask !== 4'h0 || o4_last !== 1'b0) begin miscompares++; $display("FAIL rstmid_outs: got vld=%b %h %b %b expected all 0", o4_vld, o4_data, o4_mask, o4_last); end
      vectors++; if (p4_rdy !== 1'b1) begin miscompares++; $display("FAIL rstmid_prdy: got %b expected 1", p4_rdy); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         b[i] = 16'($urandom);
         drive4(1'b1, b[i], 1'b0, 1'b1);
      end
      vectors++; if (o4_vld !== 1'b1 || o4_data !== {b[3], b[2], b[1], b[0]} || o4_mask !== 4'b1111) begin miscompares++; $display("FAIL rstmid_word: got vld=%b %h %b expected vld=1 %h 1111", o4_vld, o4_data, o4_mask, {b[3], b[2], b[1], b[0]}); end
      drive4(1'b0, '0, 1'b0, 1'b1);
   endtask

   typedef struct packed {
      logic [63:0] d;
      logic [3:0]  m;
      logic        l;
   } word_t;

   task automatic test_random;
      word_t       q[$];
      word_t       w;
      logic [63:0] cur_d;
      int          cur_n;
      int          beats;
      int          cycles;
      int          pend;
      logic        v, l, r;
      logic [15:0] d;
      cur_d = '0; cur_n = 0; beats = 0; cycles = 0;
      rstn = 1'b0; p4_vld = 0; o4_rdy = 0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      while (beats < 10000 && cycles < 40000) begin
         v = ($urandom_range(0, 3) != 0);
         d = 16'($urandom);
         l = ($urandom_range(0, 5) == 0);
         r = ($urandom_range(0, 3) != 0);
         p4_vld = v; p4_data = d; p4_last = l; o4_rdy = r;
         #1;
         pend = q.size();
         vectors++;
         if (o4_vld !== (pend > 0) || p4_rdy !== (pend < 2)) begin
            miscompares++;
            $display("FAIL rand_hs@%0d: got vld=%b rdy=%b expected vld=%b rdy=%b", cycles, o4_vld, p4_rdy, pend > 0, pend < 2);
         end
         if (pend > 0) begin
            w = q[0];
            vectors++;
            if (o4_data !== w.d || o4_mask !== w.m || o4_last !== w.l) begin
               miscompares++;
               $display("FAIL rand_word@%0d: got %h/%b/%b expected %h/%b/%b", cycles, o4_data, o4_mask, o4_last, w.d, w.m, w.l);
            end
            if (r) void'(q.pop_front());
         end
         if (v && pend < 2) begin
            cur_d[cur_n*16 +: 16] = d;
            cur_n++;
            beats++;
            if (cur_n == 4 || l) begin
               w.d = cur_d;
               w.m = 4'((1 << cur_n) - 1);
               w.l = l;
               q.push_back(w);
               cur_d = '0;
               cur_n = 0;
            end
         end
         cycles++;
         @(negedge clk);
      end
      vectors++;
      if (beats < 10000) begin
         miscompares++;
         $display("FAIL rand_budget: got %0d beats expected 10000", beats);
      end
      p4_vld = 1'b0; o4_rdy = 1'b1;
      @(negedge clk); @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_full_word;
      test_last;
      test_stall;
      test_ratio1;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
